// File: rtl/mkio_pkg.sv
// Shared definitions for the remote-terminal receive path: FSM encoding,
// pause/pulse lengths and status word field layout.
package mkio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RECV_WAIT  = 3'd1,
    ST_PAUSE_WAIT = 3'd2,
    ST_LOAD_SW    = 3'd3,
    ST_SEND_SW    = 3'd4,
    ST_END_WAIT   = 3'd5
  } rt_state_e;

  localparam logic [7:0] PAUSE_CW_SW  = 8'hFF;
  localparam logic [1:0] TX_PULSE_LEN = 2'd2;

  localparam int SW_ADDR_MSB = 15;
  localparam int SW_ADDR_LSB = 11;
  localparam int SW_MERR_BIT = 10;

  function automatic logic [15:0] status_word(input logic [4:0] addr, input logic merr);
    logic [15:0] sw;
    sw = '0;
    sw[SW_ADDR_MSB:SW_ADDR_LSB] = addr;
    sw[SW_MERR_BIT] = merr;
    return sw;
  endfunction

endpackage

// File: rtl/rt_rx_mem.sv
// 32x16 received-word buffer: one write port, registered read port.
// Contents are never reset; only the read register is.
module rt_rx_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [4:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address write/read returns the old word (read-before-write).
  always_ff @(posedge clk) begin
    if (!reset) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/rt_rx_device.sv
// Remote terminal receive controller: stores data words, pauses, then sends
// a status word. Define RT_RX_TIMEOUT_EN to enable the inter-word timeout.
module rt_rx_device #(
  parameter logic [4:0] ADDRESS      = 5'd1,
  parameter logic [7:0] WORD_TIMEOUT = 8'd100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  input  logic        p_error,
  output logic [15:0] tx_data,
  output logic        tx_cd,
  output logic        tx_ready,
  input  logic        tx_busy,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        msg_error,
  output logic [5:0]  word_cnt
);
  import mkio_pkg::*;

  rt_state_e  state;
  logic [5:0] n_words;
  logic [7:0] pause_cnt;
  logic [1:0] pulse_cnt;
  logic       mem_we;
`ifdef RT_RX_TIMEOUT_EN
  logic [7:0] tout_cnt;
`endif

  assign mem_we = reset && !start && rx_valid && (state == ST_RECV_WAIT);

  rt_rx_mem u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (word_cnt[4:0]),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      n_words   <= '0;
      pause_cnt <= '0;
      pulse_cnt <= '0;
      tx_data   <= '0;
      tx_cd     <= 1'b0;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      msg_error <= 1'b0;
      word_cnt  <= '0;
`ifdef RT_RX_TIMEOUT_EN
      tout_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (start) begin
        // A new command restarts the message from any state; a coincident data word is dropped.
        state     <= ST_RECV_WAIT;
        n_words   <= (rx_data[4:0] == 5'd0) ? 6'd32 : {1'b0, rx_data[4:0]};
        word_cnt  <= '0;
        pause_cnt <= '0;
        pulse_cnt <= '0;
        tx_ready  <= 1'b0;
        msg_error <= p_error;
        busy      <= 1'b1;
`ifdef RT_RX_TIMEOUT_EN
        tout_cnt  <= '0;
`endif
      end else begin
        case (state)
          ST_RECV_WAIT: begin
            if (rx_valid) begin
              word_cnt <= word_cnt + 6'd1;
              if (p_error) msg_error <= 1'b1;
              if (word_cnt + 6'd1 == n_words) state <= ST_PAUSE_WAIT;
`ifdef RT_RX_TIMEOUT_EN
              tout_cnt <= '0;
            end else if (tout_cnt == WORD_TIMEOUT - 8'd1) begin
              msg_error <= 1'b1;
              busy      <= 1'b0;
              tout_cnt  <= '0;
              state     <= ST_IDLE;
            end else begin
              tout_cnt <= tout_cnt + 8'd1;
`endif
            end
          end
          ST_PAUSE_WAIT: begin
            if (pause_cnt == PAUSE_CW_SW) begin
              pause_cnt <= '0;
              state     <= ST_LOAD_SW;
            end else begin
              pause_cnt <= pause_cnt + 8'd1;
            end
          end
          ST_LOAD_SW: begin
            tx_data   <= status_word(ADDRESS, msg_error);
            tx_cd     <= 1'b0;
            pulse_cnt <= '0;
            state     <= ST_SEND_SW;
          end
          ST_SEND_SW: begin
            // Request is held for TX_PULSE_LEN+1 cycles once the encoder is free.
            if (!tx_ready) begin
              if (!tx_busy) tx_ready <= 1'b1;
            end else if (pulse_cnt == TX_PULSE_LEN) begin
              tx_ready  <= 1'b0;
              pulse_cnt <= '0;
              state     <= ST_END_WAIT;
            end else begin
              pulse_cnt <= pulse_cnt + 2'd1;
            end
          end
          ST_END_WAIT: begin
            if (!tx_busy) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rt_rx_device.sv
// Scoreboard bench for rt_rx_device: expected buffer words and status words
// are queued as stimulus is driven and compared when the DUT produces them.
module tb_rt_rx_device;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        p_error = 1'b0;
  logic        tx_busy = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_ready;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic        msg_error;
  logic [5:0]  word_cnt;

  int checks = 0;
  int errors = 0;
  int ready_cycles = 0;
  int done_cnt = 0;

  logic [4:0]  exp_addr_q [$];
  logic [15:0] exp_data_q [$];
  logic [15:0] st_q [$];

  rt_rx_device #(.ADDRESS(5'd1), .WORD_TIMEOUT(8'd100)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .p_error   (p_error),
    .tx_data   (tx_data),
    .tx_cd     (tx_cd),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .msg_error (msg_error),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_ready) ready_cycles++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a message and feed nw data words, one idle cycle between words.
  task automatic send_msg(input logic [15:0] cmd, input int nw, input logic [15:0] base,
                          input int perr_idx);
    int n;
    logic err;
    logic [15:0] w;
    n = (cmd[4:0] == 5'd0) ? 32 : int'(cmd[4:0]);
    ready_cycles = 0;
    done_cnt = 0;
    start = 1'b1;
    rx_data = cmd;
    p_error = 1'b0;
    tick();
    start = 1'b0;
    err = 1'b0;
    for (int i = 0; i < nw; i++) begin
      w = base + 16'(i);
      rx_valid = 1'b1;
      rx_data = w;
      p_error = (i == perr_idx);
      if (i == perr_idx) err = 1'b1;
      exp_addr_q.push_back(5'(i));
      exp_data_q.push_back(w);
      tick();
      rx_valid = 1'b0;
      p_error = 1'b0;
      tick();
    end
    if (nw >= n) st_q.push_back({5'd1, err, 10'd0});
  endtask

  task automatic wait_done(input int n, input int exp_lat);
    int t;
    logic [15:0] exp_sw;
    t = 0;
    while (!tx_ready && t < 1000) begin
      tick();
      t++;
    end
    chk("ready_seen", 32'(t < 1000), 32'd1);
    if (exp_lat >= 0) chk("pause_lat", t, exp_lat);
    t = 0;
    while (done_cnt == 0 && t < 100) begin
      tick();
      t++;
    end
    chk("done_seen", 32'(done_cnt != 0), 32'd1);
    repeat (3) tick();
    exp_sw = (st_q.size() > 0) ? st_q.pop_front() : 16'hFFFF;
    chk("tx_data", tx_data, exp_sw);
    chk("ready_len", ready_cycles, 3);
    chk("done_once", done_cnt, 1);
    chk("busy_end", busy, 0);
    chk("wcnt_end", word_cnt, n);
    chk("tx_cd", tx_cd, 0);
  endtask

  task automatic readback();
    logic [4:0]  a;
    logic [15:0] d;
    while (exp_addr_q.size() > 0) begin
      a = exp_addr_q.pop_front();
      d = exp_data_q.pop_front();
      rd_addr = a;
      @(posedge clk);
      @(negedge clk);
      chk("rd_data", rd_data, d);
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_cd", tx_cd, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_msg_error", msg_error, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 1'b1;
    tick();

    // Three-word message, plus a stray word during the pause that must be ignored.
    send_msg(16'h0003, 3, 16'hA001, -1);
    chk("busy_pause", busy, 1);
    chk("wcnt_3", word_cnt, 3);
    rx_valid = 1'b1;
    rx_data = 16'hDEAD;
    tick();
    rx_valid = 1'b0;
    @(negedge clk);
    chk("ignore_pause", word_cnt, 3);
    wait_done(3, -1);
    chk("merr_clean", msg_error, 0);
    readback();

    // Parity error on the second word.
    send_msg(16'h0003, 3, 16'hB001, 1);
    wait_done(3, -1);
    chk("merr_sticky", msg_error, 1);
    readback();

    // N=0 means 32 words; status appears after LOAD/SEND following a 256-cycle pause.
    send_msg(16'h0000, 32, 16'hC000, -1);
    wait_done(32, 257);
    readback();
    rx_valid = 1'b1;
    rx_data = 16'hDEAD;
    tick();
    rx_valid = 1'b0;
    @(negedge clk);
    chk("ignore_idle", word_cnt, 32);
    exp_addr_q.push_back(5'd0);
    exp_data_q.push_back(16'hC000);
    readback();

    // start and rx_valid together: start wins, then encoder held busy.
    ready_cycles = 0;
    done_cnt = 0;
    start = 1'b1;
    rx_valid = 1'b1;
    rx_data = 16'h0001;
    tick();
    start = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("start_wins_wcnt", word_cnt, 0);
    chk("start_busy", busy, 1);
    chk("start_merr_clr", msg_error, 0);
    rx_valid = 1'b1;
    rx_data = 16'hD00D;
    exp_addr_q.push_back(5'd0);
    exp_data_q.push_back(16'hD00D);
    tick();
    rx_valid = 1'b0;
    tx_busy = 1'b1;
    st_q.push_back({5'd1, 1'b0, 10'd0});
    repeat (270) tick();
    chk("ready_blocked", ready_cycles, 0);
    chk("busy_blocked", busy, 1);
    tx_busy = 1'b0;
    wait_done(1, -1);
    readback();

    // Reset during the pause aborts the message; buffer survives.
    send_msg(16'h0002, 2, 16'hE000, -1);
    void'(st_q.pop_back());
    repeat (50) tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_tx_ready", tx_ready, 0);
    chk("abort_word_cnt", word_cnt, 0);
    chk("abort_tx_data", tx_data, 0);
    chk("abort_rd_data", rd_data, 0);
    reset = 1'b1;
    ready_cycles = 0;
    done_cnt = 0;
    repeat (300) tick();
    chk("abort_no_ready", ready_cycles, 0);
    chk("abort_no_done", done_cnt, 0);
    readback();
    send_msg(16'h0001, 1, 16'hF000, -1);
    wait_done(1, 257);
    chk("clean_merr", msg_error, 0);
    readback();

`ifdef RT_RX_TIMEOUT_EN
    // Only two of four words arrive: timeout drops back to idle silently.
    send_msg(16'h0004, 2, 16'h1000, -1);
    ready_cycles = 0;
    done_cnt = 0;
    repeat (110) tick();
    @(negedge clk);
    chk("tout_busy", busy, 0);
    chk("tout_merr", msg_error, 1);
    chk("tout_wcnt", word_cnt, 2);
    repeat (300) tick();
    chk("tout_no_ready", ready_cycles, 0);
    chk("tout_no_done", done_cnt, 0);
    readback();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rt_rx_device.md
RT_RX_DEVICE -- requirements
Module: rt_rx_device

Interface
REQ-001 Parameter ADDRESS, 5'd1, remote terminal address placed in status word bits [15:11].
REQ-002 Parameter WORD_TIMEOUT, 8'd100, max idle cycles allowed before first data word and between data words.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; command word valid on rx_data in the same cycle.
REQ-006 rx_data  input  16  command word (on start) or data word (on rx_valid) from channel decoder.
REQ-007 rx_valid  input  1  one-cycle strobe; data word valid on rx_data.
REQ-008 p_error  input  1  parity error flag, qualified by start or rx_valid.
REQ-009 tx_data  output  16  status word to channel encoder.
REQ-010 tx_cd  output  1  word type to encoder; 0 = command/status sync.
REQ-011 tx_ready  output  1  transmit request to encoder.
REQ-012 tx_busy  input  1  encoder transmitting.
REQ-013 rd_addr  input  5  host read address into received-word buffer.
REQ-014 rd_data  output  16  host read data, registered, 1-cycle latency.
REQ-015 busy  output  1  message in progress.
REQ-016 done  output  1  one-cycle pulse on return to IDLE after status word sent.
REQ-017 msg_error  output  1  sticky message error; cleared by start or reset.
REQ-018 word_cnt  output  6  data words stored in current message.

Function
REQ-019 Word count N = rx_data[4:0] latched on start; N = 0 SHALL mean 32 words.
REQ-020 States: IDLE, RECV_WAIT, PAUSE_WAIT, LOAD_SW, SEND_SW, END_WAIT.
REQ-021 start in any state SHALL go to RECV_WAIT, clear word_cnt, pause/timeout counters, msg_error, set busy=1; msg_error set if p_error with start.
REQ-022 start and rx_valid in the same cycle: start wins, data word discarded.
REQ-023 RECV_WAIT: on rx_valid, write rx_data to buffer address word_cnt[4:0], increment word_cnt, set msg_error if p_error; reset timeout counter.
REQ-024 When word_cnt reaches N, go to PAUSE_WAIT next cycle.
REQ-025 rx_valid outside RECV_WAIT SHALL be ignored (no write, no count change).
REQ-026 PAUSE_WAIT SHALL last exactly 256 cycles (8-bit counter 0..255), then LOAD_SW.
REQ-027 LOAD_SW: tx_data = {ADDRESS, msg_error, 10'd0}, tx_cd = 0; go to SEND_SW.
REQ-028 SEND_SW: wait while tx_busy=1; then hold tx_ready=1 for exactly 3 cycles, drop it, go to END_WAIT.
REQ-029 tx_data SHALL stay stable from LOAD_SW until next start or reset.
REQ-030 END_WAIT: when tx_busy=0, pulse done, go to IDLE, busy=0.
REQ-031 Host read port independent of FSM; simultaneous write/read same address returns pre-write contents.

Reset
REQ-032 reset=0 at a clock edge: STATE=IDLE, tx_data=0, tx_cd=0, tx_ready=0, busy=0, done=0, msg_error=0, word_cnt=0, rd_data=0, all counters 0.
REQ-033 Reset mid-message SHALL abort without status word; buffer contents are not cleared.

Configuration
REQ-034 Macro RT_RX_TIMEOUT_EN: when defined, WORD_TIMEOUT cycles in RECV_WAIT without rx_valid SHALL set msg_error, go to IDLE, busy=0, no status word, no done.
REQ-035 Without RT_RX_TIMEOUT_EN, RECV_WAIT waits indefinitely; only start or reset leaves it.

Structure
REQ-036 Package mkio_pkg SHALL hold state enum, PAUSE_CW_SW = 8'hFF, TX_PULSE_LEN = 2, status word field positions.
REQ-037 Sub-module rt_rx_mem: 32x16 buffer, one write port, registered read port.

Verification
REQ-038 start with rx_data=16'h0003, 3 rx_valid words 16'hA001/A002/A003 -> buffer[0..2] match, word_cnt=3, tx_data=16'h0800, tx_ready high 3 cycles, done once.
REQ-039 start with N=0, 32 words -> all 32 stored, word_cnt=32, status sent after 256-cycle pause.
REQ-040 p_error with word 2 of 3 -> msg_error=1, tx_data=16'h0C00.
REQ-041 tx_busy held high 10 cycles at SEND_SW entry -> tx_ready rises only after tx_busy falls.
REQ-042 RT_RX_TIMEOUT_EN defined, N=4, only 2 words -> after 100 idle cycles IDLE, msg_error=1, no tx_ready, no done.
REQ-043 reset=0 during PAUSE_WAIT -> all outputs at reset values next cycle; new start runs a clean message.
